// File: rtl/axil_rd_rr_arbiter.sv
// axil_rd_rr_arbiter: round-robin arbiter sharing one AXI4-lite read master among S_COUNT requesters
module axil_rd_rr_arbiter #(
    parameter int S_COUNT           = 4,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int FUNCTION_ID_WIDTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [S_COUNT*ADDR_WIDTH-1:0]          s_axil_araddr,
    input  logic [S_COUNT*FUNCTION_ID_WIDTH-1:0]   s_axil_aruser,
    input  logic [S_COUNT*3-1:0]                   s_axil_arprot,
    input  logic [S_COUNT-1:0]                     s_axil_arvalid,
    output logic [S_COUNT-1:0]                     s_axil_arready,
    output logic [S_COUNT*DATA_WIDTH-1:0]          s_axil_rdata,
    output logic [S_COUNT*2-1:0]                   s_axil_rresp,
    output logic [S_COUNT-1:0]                     s_axil_rvalid,
    input  logic [S_COUNT-1:0]                     s_axil_rready,
    output logic [ADDR_WIDTH-1:0]                  m_axil_araddr,
    output logic [FUNCTION_ID_WIDTH-1:0]           m_axil_aruser,
    output logic [2:0]                             m_axil_arprot,
    output logic                                   m_axil_arvalid,
    input  logic                                   m_axil_arready,
    input  logic [DATA_WIDTH-1:0]                  m_axil_rdata,
    input  logic [1:0]                             m_axil_rresp,
    input  logic                                   m_axil_rvalid,
    output logic                                   m_axil_rready,
    output logic [$clog2(S_COUNT)-1:0]             grant_index,
    output logic                                   busy
);
    localparam int IW = $clog2(S_COUNT);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                         state, state_next;
    logic [IW-1:0]                  ptr, ptr_next, win, grant_next;
    logic [IW:0]                    idx;
    logic                           found;
    logic                           arvalid_next;
    logic [ADDR_WIDTH-1:0]          araddr_next;
    logic [FUNCTION_ID_WIDTH-1:0]   aruser_next;
    logic [2:0]                     arprot_next;

    assign s_axil_rdata = {S_COUNT{m_axil_rdata}};
    assign s_axil_rresp = {S_COUNT{m_axil_rresp}};
    assign busy         = state != IDLE;

    // Pick the first requesting port at or after the pointer, wrapping around
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < S_COUNT; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(S_COUNT)) idx = idx - (IW+1)'(S_COUNT);
            if (!found && s_axil_arvalid[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    // Next state, next AR register contents and the upstream handshake/routing
    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        grant_next     = grant_index;
        arvalid_next   = m_axil_arvalid;
        araddr_next    = m_axil_araddr;
        aruser_next    = m_axil_aruser;
        arprot_next    = m_axil_arprot;
        s_axil_arready = '0;
        s_axil_rvalid  = '0;
        m_axil_rready  = 1'b0;
        case (state)
            IDLE: if (found) begin
                s_axil_arready = S_COUNT'(1) << win;
                araddr_next    = s_axil_araddr[win*ADDR_WIDTH +: ADDR_WIDTH];
                aruser_next    = s_axil_aruser[win*FUNCTION_ID_WIDTH +: FUNCTION_ID_WIDTH];
                arprot_next    = s_axil_arprot[win*3 +: 3];
                arvalid_next   = 1'b1;
                grant_next     = win;
                state_next     = ADDR;
            end
            ADDR: if (m_axil_arready) begin
                arvalid_next = 1'b0;
                state_next   = DATA;
            end
            DATA: begin
                s_axil_rvalid = S_COUNT'(m_axil_rvalid) << grant_index;
                m_axil_rready = s_axil_rready[grant_index];
                if (m_axil_rvalid && s_axil_rready[grant_index]) begin
                    ptr_next   = (grant_index == IW'(S_COUNT-1)) ? '0 : grant_index + IW'(1);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, pointer, grant and the registered AR channel toward the shared slave
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            grant_index    <= '0;
            m_axil_arvalid <= 1'b0;
            m_axil_araddr  <= '0;
            m_axil_aruser  <= '0;
            m_axil_arprot  <= '0;
        end else begin
            state          <= state_next;
            ptr            <= ptr_next;
            grant_index    <= grant_next;
            m_axil_arvalid <= arvalid_next;
            m_axil_araddr  <= araddr_next;
            m_axil_aruser  <= aruser_next;
            m_axil_arprot  <= arprot_next;
        end
    end
endmodule
